// File: rtl/earom_upload.sv
// earom_upload: serves HPS upload reads of the EAROM shadow RAM and tracks
// whether the EAROM contents have changed since the last complete upload.
// Ports:
//   clk_12, reset            clock and asynchronous active-high reset
//   ioctl_upload/index/rd    HPS upload session, index and read strobe
//   ioctl_addr               byte address qualified by ioctl_rd
//   ioctl_din, ioctl_wait    read data and stall back to the HPS side
//   ram_addr, ram_rd, ram_q  shadow RAM read port (1-cycle latency)
//   earom_wr                 game-side EAROM write pulse
//   dirty                    EAROM changed since the last complete upload
module earom_upload #(
  parameter logic [7:0]  INDEX = 8'd4,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk_12,
  input  logic                       reset,
  input  logic                       ioctl_upload,
  input  logic [7:0]                 ioctl_index,
  input  logic                       ioctl_rd,
  input  logic [24:0]                ioctl_addr,
  output logic [7:0]                 ioctl_din,
  output logic                       ioctl_wait,
  output logic [$clog2(DEPTH)-1:0]   ram_addr,
  output logic                       ram_rd,
  input  logic [7:0]                 ram_q,
  input  logic                       earom_wr,
  output logic                       dirty
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state, state_n;
  logic          sel_q;
  logic          last_seen, last_seen_n;
  logic [7:0]    din_n;
  logic          wait_n;
  logic [AW-1:0] addr_n;
  logic          dirty_n;

  logic sel_c, in_range_c, sel_rise_c, sel_fall_c;

  assign sel_c      = ioctl_upload & (ioctl_index == INDEX);
  assign in_range_c = ioctl_addr < 25'(DEPTH);
  assign sel_rise_c = sel_c & ~sel_q;
  assign sel_fall_c = ~sel_c & sel_q;

  // RAM read enable is a pure decode of the FETCH state
  assign ram_rd = (state == FETCH);

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    din_n       = ioctl_din;
    wait_n      = ioctl_wait;
    addr_n      = ram_addr;
    last_seen_n = last_seen;
    dirty_n     = dirty;

    case (state)
      IDLE: begin
        if (sel_c && ioctl_rd) begin
          if (in_range_c) begin
            addr_n  = ioctl_addr[AW-1:0];
            wait_n  = 1'b1;
            state_n = FETCH;
          end else begin
            din_n = 8'hFF;
          end
        end
      end
      FETCH: begin
        if (!sel_c) begin
          wait_n  = 1'b0;
          state_n = IDLE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        wait_n  = 1'b0;
        state_n = IDLE;
        if (sel_c) begin
          din_n = ram_q;
          if (ram_addr == AW'(DEPTH - 1)) last_seen_n = 1'b1;
        end
      end
      default: begin
        wait_n  = 1'b0;
        state_n = IDLE;
      end
    endcase

    // A new session forgets any earlier full read
    if (sel_rise_c) last_seen_n = 1'b0;

    // Clear only when a session that reached the last byte ends; a write wins
    if (sel_fall_c && last_seen) dirty_n = 1'b0;
    if (earom_wr) dirty_n = 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge clk_12 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      last_seen  <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      state      <= state_n;
      sel_q      <= sel_c;
      ioctl_din  <= din_n;
      ioctl_wait <= wait_n;
      ram_addr   <= addr_n;
      last_seen  <= last_seen_n;
      dirty      <= dirty_n;
    end
  end

endmodule

// File: tb/tb_earom_upload.sv
// tb_earom_upload: directed bench for earom_upload with a 1-cycle RAM model.
module tb_earom_upload;

  logic        clk_12;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [5:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        earom_wr;
  logic        dirty;

  logic [7:0]  mem [64];

  int total = 0;
  int bad   = 0;

  earom_upload #(.INDEX(8'd4), .DEPTH(64)) dut (
    .clk_12       (clk_12),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .earom_wr     (earom_wr),
    .dirty        (dirty)
  );

  initial begin
    clk_12 = 1'b0;
    forever #5 clk_12 = ~clk_12;
  end

  // Shadow RAM: data valid one cycle after ram_rd
  always @(posedge clk_12) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_12);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
  endtask

  task automatic do_read(input logic [24:0] a);
    strobe(a);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    mem[5] = 8'hA5;

    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    earom_wr     = 1'b0;
    ram_q        = 8'h00;

    // Reset state
    #1;
    check("rst_din",   32'(ioctl_din),  32'h0);
    check("rst_wait",  32'(ioctl_wait), 32'h0);
    check("rst_ram_rd", 32'(ram_rd),    32'h0);
    check("rst_addr",  32'(ram_addr),   32'h0);
    check("rst_dirty", 32'(dirty),      32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Basic read of address 5
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick();
    strobe(25'd5);
    check("basic_t_ram_rd", 32'(ram_rd),     32'h1);
    check("basic_t_addr",   32'(ram_addr),   32'd5);
    check("basic_t_wait",   32'(ioctl_wait), 32'h1);
    tick();
    check("basic_t1_ram_rd", 32'(ram_rd),     32'h0);
    check("basic_t1_wait",   32'(ioctl_wait), 32'h1);
    tick();
    check("basic_t2_wait", 32'(ioctl_wait), 32'h0);
    check("basic_t2_din",  32'(ioctl_din),  32'hA5);

    // Index mismatch: strobe ignored
    ioctl_index = 8'd0;
    strobe(25'd7);
    check("idx_ram_rd", 32'(ram_rd),     32'h0);
    check("idx_wait",   32'(ioctl_wait), 32'h0);
    tick();
    check("idx_din", 32'(ioctl_din), 32'hA5);
    ioctl_index = 8'd4;
    tick();

    // Out of range: exactly DEPTH, then an upper address bit
    strobe(25'd64);
    check("oor_din",    32'(ioctl_din),  32'hFF);
    check("oor_wait",   32'(ioctl_wait), 32'h0);
    check("oor_ram_rd", 32'(ram_rd),     32'h0);
    do_read(25'd3);
    check("rd3_din", 32'(ioctl_din), 32'(mem[3]));
    strobe(25'h1000005);
    check("oor_hi_din",  32'(ioctl_din),  32'hFF);
    check("oor_hi_wait", 32'(ioctl_wait), 32'h0);
    tick();

    // Dirty set, then a session ending without the last byte keeps it
    earom_wr = 1'b1;
    tick();
    earom_wr = 1'b0;
    check("wr_dirty", 32'(dirty), 32'h1);
    ioctl_upload = 1'b0;
    tick();
    tick();
    check("noread_dirty", 32'(dirty), 32'h1);

    // Full session 0..63 clears dirty on session end
    ioctl_upload = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      do_read(25'(i));
      check("full_din", 32'(ioctl_din), 32'(mem[i]));
    end
    check("full_dirty_before_end", 32'(dirty), 32'h1);
    ioctl_upload = 1'b0;
    tick();
    check("full_dirty_cleared", 32'(dirty), 32'h0);

    // Partial session 0..62 leaves dirty set
    earom_wr = 1'b1;
    tick();
    earom_wr = 1'b0;
    ioctl_upload = 1'b1;
    tick();
    for (int i = 0; i < 63; i++) do_read(25'(i));
    check("part_din", 32'(ioctl_din), 32'(mem[62]));
    ioctl_upload = 1'b0;
    tick();
    tick();
    check("part_dirty", 32'(dirty), 32'h1);

    // Write coinciding with the clearing session end: set wins
    ioctl_upload = 1'b1;
    tick();
    do_read(25'd63);
    ioctl_upload = 1'b0;
    earom_wr     = 1'b1;
    tick();
    earom_wr = 1'b0;
    check("coincide_dirty", 32'(dirty), 32'h1);

    // Reading only the last byte in a session is enough to clear
    ioctl_upload = 1'b1;
    tick();
    do_read(25'd63);
    ioctl_upload = 1'b0;
    tick();
    check("last_only_dirty", 32'(dirty), 32'h0);

    // Strobes during FETCH and WAIT are ignored
    ioctl_upload = 1'b1;
    tick();
    strobe(25'd10);
    ioctl_addr = 25'd20;
    ioctl_rd   = 1'b1;
    tick();
    check("busy_addr_t1", 32'(ram_addr), 32'd10);
    tick();
    ioctl_rd = 1'b0;
    check("busy_din",  32'(ioctl_din),  32'(mem[10]));
    check("busy_wait", 32'(ioctl_wait), 32'h0);
    check("busy_addr", 32'(ram_addr),   32'd10);
    tick();
    check("busy_no_ram_rd", 32'(ram_rd),     32'h0);
    check("busy_no_wait",   32'(ioctl_wait), 32'h0);

    // Abort in FETCH: back to idle, data held
    strobe(25'd12);
    check("abort_fetch_wait", 32'(ioctl_wait), 32'h1);
    ioctl_upload = 1'b0;
    tick();
    check("abort_wait",   32'(ioctl_wait), 32'h0);
    check("abort_ram_rd", 32'(ram_rd),     32'h0);
    check("abort_din",    32'(ioctl_din),  32'(mem[10]));
    tick();
    check("abort_din_hold", 32'(ioctl_din), 32'(mem[10]));
    check("abort_ram_rd2",  32'(ram_rd),    32'h0);

    // Reset in WAIT clears everything immediately
    earom_wr = 1'b1;
    ioctl_upload = 1'b1;
    tick();
    earom_wr = 1'b0;
    strobe(25'd13);
    tick();
    check("pre_rst_wait", 32'(ioctl_wait), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_din",   32'(ioctl_din),  32'h0);
    check("midrst_wait",  32'(ioctl_wait), 32'h0);
    check("midrst_ram_rd", 32'(ram_rd),    32'h0);
    check("midrst_addr",  32'(ram_addr),   32'h0);
    check("midrst_dirty", 32'(dirty),      32'h0);
    tick();
    reset = 1'b0;
    strobe(25'd14);
    check("postrst_wait_t", 32'(ioctl_wait), 32'h1);
    tick();
    tick();
    check("postrst_din",  32'(ioctl_din),  32'(mem[14]));
    check("postrst_wait", 32'(ioctl_wait), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/earom_upload.md
EAROM_UPLOAD -- requirements
Module: earom_upload

Interface
- REQ-001: Parameter INDEX, default 8'd4; ioctl_index value that selects this block's upload session.
- REQ-002: Parameter DEPTH, default 64; byte count of the EAROM shadow RAM (power of two, at most 256).
- REQ-003: clk_12  in  1  system clock; all logic is on the rising edge.
- REQ-004: reset  in  1  asynchronous, active-high reset.
- REQ-005: ioctl_upload  in  1  upload session active, driven by the HPS side.
- REQ-006: ioctl_index  in  8  session index.
- REQ-007: ioctl_rd  in  1  single-cycle read strobe.
- REQ-008: ioctl_addr  in  25  byte address qualified by ioctl_rd.
- REQ-009: ioctl_din  out  8  read data returned to the HPS side.
- REQ-010: ioctl_wait  out  1  stall; the HPS side holds off the next strobe while this is high.
- REQ-011: ram_addr  out  $clog2(DEPTH)  shadow RAM read address.
- REQ-012: ram_rd  out  1  shadow RAM read enable.
- REQ-013: ram_q  in  8  shadow RAM data, valid exactly 1 cycle after ram_rd.
- REQ-014: earom_wr  in  1  game-side EAROM write pulse, used to track unsaved changes.
- REQ-015: dirty  out  1  EAROM contents changed since the last complete upload.

Function
- REQ-016: Session qualifier sel = ioctl_upload & (ioctl_index == INDEX). The block ignores ioctl_rd whenever sel is 0.
- REQ-017: The FSM has 3 states:
  - IDLE: accepts strobes.
  - FETCH: ram_rd = 1 for exactly this one cycle.
  - WAIT: captures ram_q.
- REQ-018: In IDLE, when sel & ioctl_rd & (ioctl_addr < DEPTH) at edge T:
  - ram_addr <= ioctl_addr low bits.
  - ioctl_wait <= 1.
  - State goes to FETCH.
- REQ-019: At edge T+1, FETCH goes to WAIT.
- REQ-020: At edge T+2:
  - ioctl_din <= ram_q.
  - ioctl_wait <= 0.
  - State goes to IDLE.
  - Net result: data is valid and wait is low 2 cycles after the strobe edge, and ioctl_wait is high for exactly 2 cycles.
- REQ-021: When the address is out of range (ioctl_addr >= DEPTH, including any upper bit set) in IDLE:
  - ioctl_din <= 8'hFF at edge T.
  - No RAM access and no wait assertion.
  - State stays IDLE.
- REQ-022: An ioctl_rd arriving in FETCH or WAIT is ignored. No queueing; the in-flight read completes unchanged.
- REQ-023: If sel falls during FETCH or WAIT, the FSM returns to IDLE on the next edge: ioctl_wait <= 0 and ioctl_din holds its prior value.
- REQ-024: ram_rd is decoded from state FETCH only, so it is never asserted in any other state.
- REQ-025: ram_addr holds its last value between accesses.
- REQ-026: Full-read tracking: a flag last_seen is set when a read of address DEPTH-1 completes with in-range data (captured at edge T+2). It is cleared when a new session starts (rising edge of sel).
- REQ-027: Dirty flag:
  - dirty <= 1 on any earom_wr.
  - dirty <= 0 on the falling edge of sel when last_seen = 1.
  - If earom_wr coincides with the clear, set wins.
- REQ-028: A session that ends without reading DEPTH-1 leaves dirty unchanged.

Reset
- REQ-029: While reset = 1, all of the following hold asynchronously: state = IDLE, ioctl_din = 0, ioctl_wait = 0, ram_rd = 0, ram_addr = 0, dirty = 0, last_seen = 0, and the sel edge-detect register = 0.
- REQ-030: Reset asserted mid-read aborts the read immediately. After release, the block accepts a new strobe on the first edge with sel & ioctl_rd.

Verification
- REQ-031: Basic read. RAM[5] = 8'hA5, sel = 1, ioctl_rd with addr 5 at edge T -> ram_rd high only in cycle T..T+1 with ram_addr = 5; ioctl_wait high for 2 cycles; ioctl_din = 8'hA5 and wait = 0 after edge T+2.
- REQ-032: Index mismatch and out of range. ioctl_index = 0 with a strobe -> no ram_rd, ioctl_din unchanged. Correct index with addr 64 -> ioctl_din = 8'hFF after edge T, ioctl_wait stays 0.
- REQ-033: Dirty lifecycle. earom_wr pulse -> dirty = 1. Full session reading 0..63, then ioctl_upload drops -> dirty = 0. Session reading only 0..62 -> dirty stays 1.
- REQ-034: Simultaneous events. earom_wr on the same cycle as the clearing sel fall -> dirty = 1. A second ioctl_rd during WAIT -> ignored, and the first read's data is returned.
- REQ-035: Abort. ioctl_upload drops in FETCH -> IDLE next edge, ioctl_wait = 0. Reset asserted in WAIT -> all outputs 0 immediately; a strobe after release reads correctly.
